// File: rtl/cache_mem_responder.sv
// Fixed-latency single-word memory responder that sits below the cache controller.
// Optional macro MEM_STATS_EN adds saturating read_count / write_count outputs.
module cache_mem_responder #(
    parameter int WORDS   = 1024,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mreq,
    input  logic        mwrite_en,
    input  logic [31:0] maddr,
    input  logic [31:0] mdata,
    output logic [31:0] mout,
    output logic        mready,
    output logic        busy
`ifdef MEM_STATS_EN
    ,
    output logic [31:0] read_count,
    output logic [31:0] write_count
`endif
);

    localparam int IDX_W = $clog2(WORDS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             we_q, we_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      mout_q;
    logic             mready_q;
    logic             busy_q;
    logic             mout_load;

    logic [31:0] mem_q [WORDS];

    // Byte-lane bits and bits above the word index are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{maddr[31:IDX_W+2], maddr[1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (mreq) begin
                    idx_d   = maddr[IDX_W+1:2];
                    we_d    = mwrite_en;
                    wdata_d = mdata;
                    cnt_d   = CNT_INIT;
                    state_d = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Read data is fetched on the edge entering RESP so mout is stable for the whole mready cycle.
    assign mout_load = (state_d == RESP) && (state_q != RESP) && !we_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            wdata_q  <= 32'd0;
            mready_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            mready_q <= (state_d == RESP);
            busy_q   <= (state_d != IDLE);
        end
    end

    // Storage is never cleared; a write pending under reset is dropped.
    always_ff @(posedge clk) begin
        if (reset && (state_q == RESP) && we_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mout_q <= 32'd0;
        end else if (mout_load) begin
            mout_q <= mem_q[idx_d];
        end
    end

    assign mout   = mout_q;
    assign mready = mready_q;
    assign busy   = busy_q;

`ifdef MEM_STATS_EN
    logic [31:0] read_count_q;
    logic [31:0] write_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            read_count_q  <= 32'd0;
            write_count_q <= 32'd0;
        end else if (state_q == RESP) begin
            if (we_q && (write_count_q != 32'hFFFF_FFFF)) begin
                write_count_q <= write_count_q + 32'd1;
            end
            if (!we_q && (read_count_q != 32'hFFFF_FFFF)) begin
                read_count_q <= read_count_q + 32'd1;
            end
        end
    end

    assign read_count  = read_count_q;
    assign write_count = write_count_q;
`endif

endmodule
